// File: rtl/vec_pkg.sv
// Shared encodings, FSM states and width helpers for the vector execution unit.
package vec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    return (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/vec_lane.sv
// Combinational single-element ALU for vec_exec_unit.
// Defining VEC_SAT_EN makes ADD/SUB saturate signed instead of wrapping.
module vec_lane
  import vec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v
);

  localparam int MSB = DATA_W - 1;

  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              ovf;

  // SUB is a + ~b + 1 so carry-out doubles as the no-borrow flag.
  always_comb begin
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    ovf    = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
    y      = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        c = sum[DATA_W];
        v = ovf;
`ifdef VEC_SAT_EN
        y = ovf ? (a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}}) : sum[MSB:0];
`else
        y = sum[MSB:0];
`endif
      end
      OP_AND:  y = a & b;
      OP_ORR:  y = a | b;
      OP_EOR:  y = a ^ b;
      OP_MOV:  y = b;
      default: y = '0;
    endcase
    n = y[MSB];
    z = (y == '0);
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Multicycle vector execution unit: register file, LANES-wide element-wise ALU and flag accumulation.
// Optional VEC_SAT_EN (see vec_lane) selects saturating ADD/SUB.
module vec_exec_unit
  import vec_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_VREGS = 16,
  parameter int MAX_VLEN  = 8,
  parameter int LANES     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     op,
  input  logic [idx_w(NUM_VREGS)-1:0]    vd,
  input  logic [idx_w(NUM_VREGS)-1:0]    va,
  input  logic [idx_w(NUM_VREGS)-1:0]    vb,
  input  logic [idx_w(MAX_VLEN+1)-1:0]   vlen,
  output logic                           busy,
  output logic                           done,
  output logic [3:0]                     flags,
  input  logic                           ld_we,
  input  logic [idx_w(NUM_VREGS)-1:0]    ld_vreg,
  input  logic [idx_w(MAX_VLEN)-1:0]     ld_elem,
  input  logic [DATA_W-1:0]              ld_data,
  input  logic [idx_w(NUM_VREGS)-1:0]    rd_vreg,
  input  logic [idx_w(MAX_VLEN)-1:0]     rd_elem,
  output logic [DATA_W-1:0]              rd_data
);

  localparam int VREG_W = idx_w(NUM_VREGS);
  localparam int ELEM_W = idx_w(MAX_VLEN);
  localparam int VLEN_W = idx_w(MAX_VLEN + 1);
  localparam int IDX_W  = idx_w(MAX_VLEN + LANES + 1);

  logic [DATA_W-1:0] rf_q [NUM_VREGS][MAX_VLEN];
  logic [DATA_W-1:0] rf_d [NUM_VREGS][MAX_VLEN];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [VREG_W-1:0] vd_q, vd_d, va_q, va_d, vb_q, vb_d;
  logic [VLEN_W-1:0] vlen_q, vlen_d, vlen_eff;
  logic [3:0]        flags_q, flags_d, flags_acc;
  logic              busy_q, busy_d, done_q, done_d;
  logic              last_chunk, ld_en;

  logic [DATA_W-1:0] lane_y   [LANES];
  logic [ELEM_W-1:0] lane_idx [LANES];
  logic [LANES-1:0]  lane_act, lane_we, lane_n, lane_z, lane_c, lane_v;

  assign vlen_eff   = (32'(vlen) > MAX_VLEN) ? VLEN_W'(MAX_VLEN) : vlen;
  assign last_chunk = (idx_q + IDX_W'(LANES)) >= IDX_W'(vlen_q);
  assign ld_en      = ld_we && (state_q != ST_EXEC) &&
                      (32'(ld_elem) < MAX_VLEN) && (32'(ld_vreg) < NUM_VREGS);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] elem;
    assign elem        = idx_q + IDX_W'(l);
    assign lane_act[l] = (state_q == ST_EXEC) && (elem < IDX_W'(vlen_q));
    // Masked lanes read element 0 so the array index always stays in range.
    assign lane_idx[l] = lane_act[l] ? elem[ELEM_W-1:0] : '0;
    assign lane_we[l]  = lane_act[l] && op_valid(op_q) && !reset;

    vec_lane #(.DATA_W(DATA_W)) u_lane (
      .a  (rf_q[va_q][lane_idx[l]]),
      .b  (rf_q[vb_q][lane_idx[l]]),
      .op (op_q),
      .y  (lane_y[l]),
      .n  (lane_n[l]),
      .z  (lane_z[l]),
      .c  (lane_c[l]),
      .v  (lane_v[l])
    );
  end

  // Fold this chunk's unmasked lanes into the running {N,Z,C,V}.
  always_comb begin
    flags_acc = flags_q;
    for (int l = 0; l < LANES; l++) begin
      flags_acc[3] = flags_acc[3] | (lane_we[l] & lane_n[l]);
      flags_acc[2] = flags_acc[2] & (~lane_we[l] | lane_z[l]);
      flags_acc[1] = flags_acc[1] | (lane_we[l] & lane_c[l]);
      flags_acc[0] = flags_acc[0] | (lane_we[l] & lane_v[l]);
    end
  end

  // Register file update: loads only outside EXEC, lane results only inside it.
  always_comb begin
    rf_d = rf_q;
    rf_d[ld_vreg][ld_elem] = ld_en ? ld_data : rf_d[ld_vreg][ld_elem];
    for (int l = 0; l < LANES; l++) begin
      rf_d[vd_q][lane_idx[l]] = lane_we[l] ? lane_y[l] : rf_d[vd_q][lane_idx[l]];
    end
  end

  // Next-state and latched-operand logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    vd_d    = vd_q;
    va_d    = va_q;
    vb_d    = vb_q;
    vlen_d  = vlen_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXEC;
          idx_d   = '0;
          op_d    = op;
          vd_d    = vd;
          va_d    = va;
          vb_d    = vb;
          vlen_d  = vlen_eff;
          flags_d = op_valid(op) ? 4'b0100 : 4'b0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        idx_d   = idx_q + IDX_W'(LANES);
        flags_d = flags_acc;
        state_d = last_chunk ? ST_DONE : ST_EXEC;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_EXEC);
    done_d = (state_d == ST_DONE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= OP_ADD;
      vd_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      vlen_q  <= '0;
      flags_q <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      vd_q    <= vd_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vlen_q  <= vlen_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Register file storage is deliberately not reset.
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign flags   = flags_q;
  assign rd_data = ((32'(rd_elem) < MAX_VLEN) && (32'(rd_vreg) < NUM_VREGS)) ?
                   rf_q[rd_vreg][rd_elem] : '0;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed self-checking bench for vec_exec_unit (LANES=2, MAX_VLEN=8, DATA_W=32).
module tb_vec_exec_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b110;
`ifdef VEC_SAT_EN
  localparam logic [31:0] OVF_RES   = 32'h7FFF_FFFF;
  localparam logic [3:0]  OVF_FLAGS = 4'b0001;
`else
  localparam logic [31:0] OVF_RES   = 32'h8000_0000;
  localparam logic [3:0]  OVF_FLAGS = 4'b1001;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [3:0]  vd = 4'd0, va = 4'd0, vb = 4'd0;
  logic [3:0]  vlen = 4'd0;
  logic        busy, done;
  logic [3:0]  flags;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_vreg = 4'd0;
  logic [2:0]  ld_elem = 3'd0;
  logic [31:0] ld_data = 32'd0;
  logic [3:0]  rd_vreg = 4'd0;
  logic [2:0]  rd_elem = 3'd0;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;

  vec_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .vd(vd), .va(va), .vb(vb), .vlen(vlen),
    .busy(busy), .done(done), .flags(flags),
    .ld_we(ld_we), .ld_vreg(ld_vreg), .ld_elem(ld_elem), .ld_data(ld_data),
    .rd_vreg(rd_vreg), .rd_elem(rd_elem), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] r, input logic [2:0] e, input logic [31:0] d);
    ld_we = 1'b1; ld_vreg = r; ld_elem = e; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] r, input logic [2:0] e,
                        input logic [31:0] exp);
    rd_vreg = r; rd_elem = e;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] d,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] l,
                        input int exp_cyc, input logic [3:0] exp_flags);
    int n;
    op = o; vd = d; va = a; vb = b; vlen = l; start = 1'b1;
    tick();
    start = 1'b0; ld_we = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      tick();
    end
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_flags});
    tick();
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic [31:0] va_tab [8];
    logic [31:0] vb_tab [8];

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      va_tab[i] = 32'(i + 1);
      vb_tab[i] = 32'(10 * (i + 1));
      load(4'd1, 3'(i), va_tab[i]);
      load(4'd2, 3'(i), vb_tab[i]);
    end

    // 1: full-length ADD
    run_op("add8", OP_ADD, 4'd3, 4'd1, 4'd2, 4'd8, 4, 4'b0000);
    for (int i = 0; i < 8; i++) rd_chk("add8_v3", 4'd3, 3'(i), 32'(11 * (i + 1)));

    // 2: partial SUB to zero, tail untouched
    for (int i = 0; i < 8; i++) load(4'd3, 3'(i), 32'h0000_00FF);
    run_op("sub5", OP_SUB, 4'd3, 4'd1, 4'd1, 4'd5, 3, 4'b0110);
    for (int i = 0; i < 8; i++) rd_chk("sub5_v3", 4'd3, 3'(i), (i < 5) ? 32'd0 : 32'h0000_00FF);

    // 3: vlen 0 and vlen beyond MAX_VLEN
    run_op("vlen0", OP_ADD, 4'd3, 4'd1, 4'd2, 4'd0, 1, 4'b0100);
    rd_chk("vlen0_v3_0", 4'd3, 3'd0, 32'd0);
    rd_chk("vlen0_v3_7", 4'd3, 3'd7, 32'h0000_00FF);
    run_op("vlen12", OP_ADD, 4'd6, 4'd1, 4'd2, 4'd12, 4, 4'b0000);
    rd_chk("vlen12_v6_0", 4'd6, 3'd0, 32'd11);
    rd_chk("vlen12_v6_7", 4'd6, 3'd7, 32'd88);

    // 4: signed overflow
    load(4'd4, 3'd0, 32'h7FFF_FFFF);
    load(4'd5, 3'd0, 32'd1);
    run_op("ovf", OP_ADD, 4'd7, 4'd4, 4'd5, 4'd1, 1, OVF_FLAGS);
    rd_chk("ovf_v7", 4'd7, 3'd0, OVF_RES);

    // SUB with borrow, EOR, reserved op
    run_op("borrow", OP_SUB, 4'd8, 4'd1, 4'd2, 4'd1, 1, 4'b1000);
    rd_chk("borrow_v8", 4'd8, 3'd0, 32'hFFFF_FFF7);
    run_op("eor", OP_EOR, 4'd8, 4'd1, 4'd2, 4'd2, 1, 4'b0000);
    rd_chk("eor_v8_0", 4'd8, 3'd0, 32'd11);
    rd_chk("eor_v8_1", 4'd8, 3'd1, 32'd22);
    run_op("rsv", OP_RSV, 4'd8, 4'd1, 4'd2, 4'd8, 4, 4'b0000);
    rd_chk("rsv_v8_0", 4'd8, 3'd0, 32'd11);

    // 5a: start re-pulsed while busy
    op = OP_ADD; vd = 4'd3; va = 4'd1; vb = 4'd2; vlen = 4'd8; start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) cnt++;
      start = (i < 3) ? 1'b1 : 1'b0;
      op = OP_SUB; vd = 4'd5;
    end
    start = 1'b0;
    chk("repulse_dones", cnt, 32'd1);
    chk("repulse_busy", {31'd0, busy}, 32'd0);
    rd_chk("repulse_v3_0", 4'd3, 3'd0, 32'd11);
    rd_chk("repulse_v3_7", 4'd3, 3'd7, 32'd88);

    // 5b: reset in the second EXEC cycle
    for (int i = 0; i < 8; i++) load(4'd3, 3'(i), 32'h0000_00FF);
    op = OP_ADD; vd = 4'd3; va = 4'd1; vb = 4'd2; vlen = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_flags", {28'd0, flags}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("mrst_quiet", cnt, 32'd0);
    for (int i = 0; i < 8; i++)
      rd_chk("mrst_v3", 4'd3, 3'(i), (i < 2) ? 32'(11 * (i + 1)) : 32'h0000_00FF);

    // Load in the same cycle as the accepted start is seen by the op
    ld_we = 1'b1; ld_vreg = 4'd4; ld_elem = 3'd1; ld_data = 32'd7;
    run_op("ldstart", OP_ADD, 4'd10, 4'd4, 4'd2, 4'd2, 1, OVF_FLAGS);
    rd_chk("ldstart_v10_1", 4'd10, 3'd1, 32'd27);

    // 6: in-place ORR, load attempted while busy
    load(4'd9, 3'd0, 32'd5);
    op = OP_ORR; vd = 4'd1; va = 4'd1; vb = 4'd2; vlen = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    ld_we = 1'b1; ld_vreg = 4'd9; ld_elem = 3'd0; ld_data = 32'h0000_DEAD;
    tick();
    ld_we = 1'b0;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      tick();
    end
    chk("orr_done", {31'd0, done}, 32'd1);
    rd_chk("busy_ld_v9", 4'd9, 3'd0, 32'd5);
    for (int i = 0; i < 8; i++) rd_chk("orr_v1", 4'd1, 3'(i), va_tab[i] | vb_tab[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
